// File: rtl/eth_rx_sequencer.sv
// eth_rx_sequencer: frames received bytes through the MAC destination filter,
// waits for the filter verdict, then stores accepted frames for the CPU.
module eth_rx_sequencer #(
    parameter int unsigned BUF_AW        = 11,
    parameter int unsigned DECIDE_CYCLES = 2,
    parameter int unsigned MIN_LEN       = 14
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_sof,
    input  logic              rx_eof,
    input  logic              rx_err,
    output logic              f_n_ss,
    output logic [7:0]        f_d,
    output logic [3:0]        f_a,
    output logic              f_n_we,
    input  logic              f_n_inhibit,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              frame_ready,
    output logic [BUF_AW:0]   frame_len,
    input  logic              frame_ack,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned CNT_W = BUF_AW + 1;
    localparam int unsigned DEC_W = (DECIDE_CYCLES > 1) ? $clog2(DECIDE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BUF_DEPTH = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(5);
    localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(DECIDE_CYCLES - 1);
    localparam logic [3:0]       FA_PARK   = 4'hF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_DECIDE = 3'd2;
    localparam logic [2:0] S_BODY   = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;
    localparam logic [2:0] S_READY  = 3'd5;

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
    logic [DEC_W-1:0]  dec_cnt, dec_cnt_nxt;
    logic              last_valid;

    logic              f_n_ss_nxt, f_n_we_nxt, buf_we_nxt, frame_ready_nxt;
    logic [7:0]        f_d_nxt, buf_wdata_nxt, drop_cnt_nxt;
    logic [3:0]        f_a_nxt;
    logic [BUF_AW-1:0] buf_addr_nxt;
    logic [BUF_AW:0]   frame_len_nxt;

    logic              proto_err, err, vld, in_frame, decide_now;
    logic              drop_inc, start_frame, end_frame, wr_buf, wr_flt;
    logic [CNT_W-1:0]  wr_idx, len_c;

    // Back-to-back strobes violate the input contract and count as receive errors.
    assign proto_err  = rx_valid & last_valid;
    assign err        = rx_err | proto_err;
    assign vld        = rx_valid & ~proto_err;
    assign in_frame   = (state == S_HDR) || (state == S_DECIDE) || (state == S_BODY);
    assign decide_now = (dec_cnt == DEC_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        byte_cnt_nxt    = byte_cnt;
        dec_cnt_nxt     = dec_cnt;
        f_n_ss_nxt      = f_n_ss;
        f_d_nxt         = f_d;
        f_a_nxt         = f_a;
        f_n_we_nxt      = 1'b1;
        buf_we_nxt      = 1'b0;
        buf_addr_nxt    = buf_addr;
        buf_wdata_nxt   = buf_wdata;
        frame_ready_nxt = frame_ready;
        frame_len_nxt   = frame_len;
        drop_cnt_nxt    = drop_cnt;
        drop_inc        = 1'b0;
        start_frame     = 1'b0;
        end_frame       = 1'b0;
        wr_buf          = 1'b0;
        wr_flt          = 1'b0;
        wr_idx          = byte_cnt;
        len_c           = byte_cnt + CNT_W'(1);

        // Park the filter index only once the last write strobe has risen.
        if (state != S_HDR && f_n_we) begin
            f_a_nxt = FA_PARK;
        end

        if (in_frame && err) begin
            drop_inc = 1'b1;
            if (vld && rx_eof) begin
                end_frame = 1'b1;
            end else begin
                state_nxt = S_DROP;
            end
        end else if (in_frame && vld && rx_sof) begin
            drop_inc    = 1'b1;
            start_frame = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (vld && rx_sof) begin
                        start_frame = 1'b1;
                    end
                end
                S_HDR: begin
                    if (vld) begin
                        if (rx_eof) begin
                            drop_inc  = 1'b1;
                            end_frame = 1'b1;
                        end else begin
                            wr_buf = 1'b1;
                            wr_flt = 1'b1;
                            if (byte_cnt == HDR_LAST) begin
                                state_nxt   = S_DECIDE;
                                dec_cnt_nxt = '0;
                            end
                        end
                    end
                end
                S_DECIDE: begin
                    if (vld && rx_eof) begin
                        drop_inc  = 1'b1;
                        end_frame = 1'b1;
                    end else if (decide_now && !f_n_inhibit) begin
                        drop_inc  = 1'b1;
                        state_nxt = S_DROP;
                    end else begin
                        wr_buf = vld;
                        if (decide_now) begin
                            state_nxt = S_BODY;
                        end else begin
                            dec_cnt_nxt = dec_cnt + DEC_W'(1);
                        end
                    end
                end
                S_BODY: begin
                    if (vld) begin
                        if (byte_cnt == BUF_DEPTH) begin
                            drop_inc = 1'b1;
                            if (rx_eof) begin
                                end_frame = 1'b1;
                            end else begin
                                state_nxt = S_DROP;
                            end
                        end else begin
                            wr_buf = 1'b1;
                            if (rx_eof) begin
                                if (len_c < MIN_LEN_C) begin
                                    drop_inc  = 1'b1;
                                    end_frame = 1'b1;
                                end else begin
                                    frame_len_nxt   = len_c;
                                    frame_ready_nxt = 1'b1;
                                    f_n_ss_nxt      = 1'b1;
                                    state_nxt       = S_READY;
                                end
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (vld && rx_sof && !err) begin
                        start_frame = 1'b1;
                    end else if (vld && rx_eof) begin
                        end_frame = 1'b1;
                    end
                end
                S_READY: begin
                    if (vld && rx_sof) begin
                        drop_inc = 1'b1;
                    end
                    if (frame_ack) begin
                        frame_ready_nxt = 1'b0;
                        state_nxt       = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        // A single-byte frame is dropped outright; otherwise byte 0 opens the header.
        if (start_frame) begin
            if (rx_eof) begin
                drop_inc  = 1'b1;
                end_frame = 1'b1;
            end else begin
                f_n_ss_nxt = 1'b0;
                wr_buf     = 1'b1;
                wr_flt     = 1'b1;
                wr_idx     = '0;
                state_nxt  = S_HDR;
            end
        end

        if (end_frame) begin
            f_n_ss_nxt = 1'b1;
            f_a_nxt    = FA_PARK;
            state_nxt  = S_IDLE;
        end

        if (wr_buf) begin
            buf_we_nxt    = 1'b1;
            buf_addr_nxt  = BUF_AW'(wr_idx);
            buf_wdata_nxt = rx_data;
            byte_cnt_nxt  = wr_idx + CNT_W'(1);
        end

        if (wr_flt) begin
            f_n_we_nxt = 1'b0;
            f_d_nxt    = rx_data;
            f_a_nxt    = 4'(wr_idx);
        end

        if (drop_inc && drop_cnt != 8'hFF) begin
            drop_cnt_nxt = drop_cnt + 8'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            dec_cnt     <= '0;
            last_valid  <= 1'b0;
            f_n_ss      <= 1'b1;
            f_d         <= 8'd0;
            f_a         <= FA_PARK;
            f_n_we      <= 1'b1;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= 8'd0;
            frame_ready <= 1'b0;
            frame_len   <= '0;
            drop_cnt    <= 8'd0;
        end else begin
            state       <= state_nxt;
            byte_cnt    <= byte_cnt_nxt;
            dec_cnt     <= dec_cnt_nxt;
            last_valid  <= rx_valid;
            f_n_ss      <= f_n_ss_nxt;
            f_d         <= f_d_nxt;
            f_a         <= f_a_nxt;
            f_n_we      <= f_n_we_nxt;
            buf_we      <= buf_we_nxt;
            buf_addr    <= buf_addr_nxt;
            buf_wdata   <= buf_wdata_nxt;
            frame_ready <= frame_ready_nxt;
            frame_len   <= frame_len_nxt;
            drop_cnt    <= drop_cnt_nxt;
        end
    end

endmodule
